uart_cmd_deframer: RTL and testbench
====================================

# uart_cmd_deframer

FPGA-side receiver for the host UART command stream: takes bytes from the UART receiver (`rxdata`/`rxvalid`), finds the 16-byte sync preamble, and packs each following group of 8 bytes, most significant byte first, into one 64-bit local-bus command word {ctrl[7:0], addr[23:0], data[31:0]}. It sits between the UART core in the hardware-config block and the local-bus register file. It presents words on a valid/ready handshake and reports framing status.

## Interface
- `TIMEOUT`, 4096: idle clocks allowed between bytes of one word before the partial word is discarded; 0 disables the timeout.
- `NSYNCFF`, 15: count of consecutive 0xff bytes that must precede 0x00 to form sync.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `rxdata`  in  8  received byte; qualified by `rxvalid`.
- `rxvalid`  in  1  one-cycle strobe per received byte.
- `cmd`  out  64  assembled command word; first received byte is in bits [63:56].
- `cmd_valid`  out  1  `cmd` holds an unconsumed word.
- `cmd_ready`  in  1  consumer accepts `cmd` when `cmd_valid & cmd_ready`.
- `aligned`  out  1  sync has been seen since reset.
- `overflow`  out  1  sticky: a completed word was dropped because the output was still full.
- `timeout_err`  out  1  sticky: a partial word was discarded by the timeout.
- `clr`  in  1  synchronous clear of `overflow` and `timeout_err`.
- `wordcnt`  out  16  count of words accepted by the consumer; wraps 0xffff to 0.

## Operation
- States: HUNT (reset state) and ALIGNED. `aligned`=1 only in ALIGNED.
- The sync detector runs in every state.
  - `ffcnt` is 4 bits and saturates at `NSYNCFF`.
  - A byte of 0xff increments `ffcnt`; any other byte clears it.
  - A byte of 0x00 arriving while `ffcnt`>=`NSYNCFF` is a sync event.
- Sync event, from any state:
  - go to ALIGNED and set the byte index to 0;
  - discard any partial word;
  - the sync bytes never produce a word.
  - Sync takes priority over word completion on the same byte.
- HUNT: bytes feed only the sync detector.
- ALIGNED: each byte shifts into a 64-bit shift register (`sr <= {sr[55:0], rxdata}`) and the byte index increments 0..7.
- Word completion: the 8th byte (index 7) completes a word, and the index wraps to 0.
  - If the output is empty, or is being accepted in the same cycle, `cmd` <= {sr[55:0], rxdata} and `cmd_valid` <= 1.
  - Otherwise the new word is dropped, `overflow` <= 1, and the held `cmd` is unchanged.
- Output handshake:
  - `cmd_valid` falls after `cmd_valid & cmd_ready` unless a new word loads in that same cycle.
  - `cmd` is stable while `cmd_valid`=1 and not accepted.
- Timeout:
  - An idle counter clears on every `rxvalid` and counts while the byte index is non-zero.
  - When it reaches `TIMEOUT`: the index returns to 0, `timeout_err` <= 1, and the state stays ALIGNED.
- Data bytes inside ALIGNED also feed the sync detector. A word body containing 15×0xff followed by 0x00 resyncs; the host never sends such a word.
- `wordcnt` increments on each accepted handshake.
- `clr`:
  - clears the sticky flags in the next cycle;
  - a set event in the same cycle wins, leaving the flag at 1.

## Timing
- Reset values: state HUNT, `aligned`=0, `cmd`=0, `cmd_valid`=0, `overflow`=0, `timeout_err`=0, `wordcnt`=0, `ffcnt`=0, byte index 0, idle counter 0.
- Latency: the `rxvalid` of the 8th byte in cycle N gives `cmd_valid`=1 in cycle N+1.
- Sync: the `rxvalid` of 0x00 in cycle N gives `aligned`=1 in cycle N+1.
- A word can be accepted the same cycle `cmd_valid` rises. The minimum byte spacing is 1 clock; every byte must be taken at full rate.
- Reset mid-word or mid-handshake: all state returns to the reset values immediately (asynchronous). Alignment is lost and the host must resend sync.
- Timeout fires exactly `TIMEOUT` clocks after the last `rxvalid` of a partial word.

## Test plan
- Sync plus commands:
  - stimulus: bytes ff×15, 00, then 01 00 00 17 00 e0 22 81 and 01 00 00 18 00 00 00 01, with `cmd_ready`=1;
  - response: `aligned`=1 after the 00, then two `cmd` words 0x0100001700e02281 and 0x0100001800000001, and `wordcnt`=2.
- No sync:
  - stimulus: 16 arbitrary bytes with no preamble;
  - response: `aligned`=0 and `cmd_valid` never asserts.
- Backpressure:
  - stimulus: `cmd_ready`=0, then two full words 0x00000000facefeed and 0x00000001deadbeef;
  - response: `cmd` holds facefeed, `overflow`=1, and `wordcnt`=0; after `clr` then `cmd_ready`=1, exactly one word is accepted and `overflow`=0.
- Simultaneous events:
  - stimulus: the 8th byte arrives in the same cycle the consumer accepts the previous word;
  - response: the new word loads, `cmd_valid` stays 1, and `overflow`=0.
- Timeout (TIMEOUT=16):
  - stimulus: 3 bytes of a word, 20 idle clocks, then 8 bytes 0100001500000000;
  - response: `timeout_err`=1 and `cmd`=0x0100001500000000.
- Resync and reset:
  - stimulus: 4 bytes of a word, then ff×15 and 00, then a full word;
  - response: the partial word is discarded and the word aligns correctly.
  - stimulus: `rstn` pulsed low mid-word;
  - response: all outputs return to their reset values.

Source files
------------

// File: rtl/uart_cmd_deframer.sv
// UART command deframer: hunts for the 0xff..0xff,0x00 preamble, then packs
// each group of 8 bytes MSB-first into a 64-bit local-bus command word.
module uart_cmd_deframer #(
    parameter int TIMEOUT = 4096,
    parameter int NSYNCFF = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rxdata,
    input  logic        rxvalid,
    output logic [63:0] cmd,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        aligned,
    output logic        overflow,
    output logic        timeout_err,
    input  logic        clr,
    output logic [15:0] wordcnt
);

    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0] NFF = 4'(NSYNCFF);

    typedef enum logic {HUNT, ALIGNED} state_t;

    state_t state, state_nx;

    logic [3:0]    ffcnt;
    logic [2:0]    idx;
    logic [IW-1:0] idle;
    logic [55:0]   sr;
    logic          sync;
    logic          take;
    logic          done;
    logic          accept;
    logic          tmo;

    assign sync   = rxvalid && (rxdata == 8'h00) && (ffcnt >= NFF);
    assign take   = rxvalid && !sync && (state == ALIGNED);
    assign done   = take && (idx == 3'd7);
    assign accept = cmd_valid && cmd_ready;
    assign tmo    = (TIMEOUT != 0) && !rxvalid && (idx != 3'd0) &&
                    (idle == IW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= HUNT;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (sync) state_nx = ALIGNED;
    end

    always_comb begin
        aligned = (state == ALIGNED);
    end

    // Sync detector runs on every byte, including data bytes in ALIGNED.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ffcnt <= '0;
        end else if (rxvalid) begin
            if (rxdata != 8'hff)  ffcnt <= '0;
            else if (ffcnt < NFF) ffcnt <= ffcnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx  <= '0;
            idle <= '0;
            sr   <= '0;
        end else begin
            if (sync)      idx <= '0;
            else if (take) idx <= idx + 3'd1;
            else if (tmo)  idx <= '0;
            if (rxvalid || idx == 3'd0 || tmo) idle <= '0;
            else                               idle <= idle + 1'b1;
            if (take) sr <= {sr[47:0], rxdata};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd         <= '0;
            cmd_valid   <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            wordcnt     <= '0;
        end else begin
            if (done && (!cmd_valid || cmd_ready)) begin
                cmd       <= {sr, rxdata};
                cmd_valid <= 1'b1;
            end else if (accept) begin
                cmd_valid <= 1'b0;
            end
            // A set in the same cycle as clr leaves the flag high.
            overflow    <= (done && cmd_valid && !cmd_ready) ||
                           (overflow && !clr);
            timeout_err <= tmo || (timeout_err && !clr);
            if (accept) wordcnt <= wordcnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Bench for uart_cmd_deframer: directed scenarios plus a randomized run,
// all checked against a byte-queue reference model.
module tb_uart_cmd_deframer;

    localparam int TMO   = 16;
    localparam int NSYNC = 15;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rxdata = '0;
    logic        rxvalid = 1'b0;
    logic [63:0] cmd;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        aligned;
    logic        overflow;
    logic        timeout_err;
    logic        clr = 1'b0;
    logic [15:0] wordcnt;

    int n_cmp = 0;
    int n_err = 0;

    int          m_run;
    bit          m_al;
    logic [7:0]  m_part[$];
    int          m_idle;
    bit          m_full;
    logic [63:0] m_cmd;
    bit          m_ov;
    bit          m_to;
    logic [15:0] m_cnt;

    uart_cmd_deframer #(.TIMEOUT(TMO), .NSYNCFF(NSYNC)) dut (
        .clk(clk),
        .rstn(rstn),
        .rxdata(rxdata),
        .rxvalid(rxvalid),
        .cmd(cmd),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .aligned(aligned),
        .overflow(overflow),
        .timeout_err(timeout_err),
        .clr(clr),
        .wordcnt(wordcnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run = 0;
        m_al = 0;
        m_part.delete();
        m_idle = 0;
        m_full = 0;
        m_cmd = '0;
        m_ov = 0;
        m_to = 0;
        m_cnt = '0;
    endtask

    // Drive one clock of inputs, advance the model, sample 1 time unit
    // after the edge.
    task automatic step(input bit v, input logic [7:0] d,
                        input bit rdy, input bit c);
        bit so;
        bit st;
        bit syn;
        logic [63:0] w;
        rxvalid = v;
        rxdata = d;
        cmd_ready = rdy;
        clr = c;
        so = 0;
        st = 0;
        syn = 0;
        if (m_full && rdy) begin
            m_full = 0;
            m_cnt = m_cnt + 16'd1;
        end
        if (v) begin
            m_idle = 0;
            if (d == 8'hff) begin
                m_run++;
            end else begin
                if (d == 8'h00 && m_run >= NSYNC) syn = 1;
                m_run = 0;
            end
            if (syn) begin
                m_al = 1;
                m_part.delete();
            end else if (m_al) begin
                m_part.push_back(d);
                if (m_part.size() == 8) begin
                    w = '0;
                    foreach (m_part[i]) w = {w[55:0], m_part[i]};
                    m_part.delete();
                    if (m_full) begin
                        so = 1;
                    end else begin
                        m_cmd = w;
                        m_full = 1;
                    end
                end
            end
        end else if (m_part.size() > 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_part.delete();
                m_idle = 0;
                st = 1;
            end
        end
        m_ov = so || (m_ov && !c);
        m_to = st || (m_to && !c);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rxvalid = 0;
        cmd_ready = 0;
        clr = 0;
        rstn = 0;
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sync(input bit rdy);
        for (int i = 0; i < NSYNC; i++) step(1, 8'hff, rdy, 0);
        step(1, 8'h00, rdy, 0);
    endtask

    task automatic send_word(input logic [63:0] w, input bit rdy);
        for (int i = 7; i >= 0; i--) step(1, w[i*8 +: 8], rdy, 0);
    endtask

    task automatic test_reset();
        rstn = 0;
        #2;
        n_cmp++;
        if (aligned !== 1'b0 || cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags aligned=%b valid=%b want 0 0",
                     aligned, cmd_valid);
        end
        do_reset();
        n_cmp++;
        if (cmd !== 64'h0) begin
            n_err++;
            $display("FAIL reset_cmd got %h want 0", cmd);
        end
        n_cmp++;
        if (overflow !== 1'b0 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_sticky ov=%b to=%b want 0 0",
                     overflow, timeout_err);
        end
        n_cmp++;
        if (wordcnt !== 16'h0) begin
            n_err++;
            $display("FAIL reset_wordcnt got %0d want 0", wordcnt);
        end
    endtask

    task automatic test_sync_cmds();
        do_reset();
        for (int i = 0; i < NSYNC; i++) step(1, 8'hff, 1, 0);
        n_cmp++;
        if (aligned !== 1'b0) begin
            n_err++;
            $display("FAIL sync_early aligned=%b want 0", aligned);
        end
        step(1, 8'h00, 1, 0);
        n_cmp++;
        if (aligned !== 1'b1) begin
            n_err++;
            $display("FAIL sync_aligned got %b want 1", aligned);
        end
        send_word(64'h0100001700e02281, 1);
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd !== 64'h0100001700e02281) begin
            n_err++;
            $display("FAIL sync_word1 valid=%b cmd=%h want 1 %h",
                     cmd_valid, cmd, 64'h0100001700e02281);
        end
        send_word(64'h0100001800000001, 1);
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd !== 64'h0100001800000001) begin
            n_err++;
            $display("FAIL sync_word2 valid=%b cmd=%h want 1 %h",
                     cmd_valid, cmd, 64'h0100001800000001);
        end
        step(0, 8'h00, 1, 0);
        n_cmp++;
        if (wordcnt !== 16'd2 || cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sync_wordcnt cnt=%0d valid=%b want 2 0",
                     wordcnt, cmd_valid);
        end
    endtask

    task automatic test_no_sync();
        bit seen;
        do_reset();
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, 8'($urandom_range(1, 254)), 1, 0);
            if (cmd_valid || aligned) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL no_sync valid/aligned rose got 1 want 0");
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        send_sync(0);
        send_word(64'h00000000facefeed, 0);
        send_word(64'h00000001deadbeef, 0);
        n_cmp++;
        if (cmd !== 64'h00000000facefeed || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold cmd=%h ov=%b want %h 1",
                     cmd, overflow, 64'h00000000facefeed);
        end
        n_cmp++;
        if (wordcnt !== 16'd0) begin
            n_err++;
            $display("FAIL bp_cnt got %0d want 0", wordcnt);
        end
        step(0, 8'h00, 0, 1);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++;
            $display("FAIL bp_clr ov=%b want 0", overflow);
        end
        repeat (3) step(0, 8'h00, 1, 0);
        n_cmp++;
        if (wordcnt !== 16'd1 || cmd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept cnt=%0d valid=%b want 1 0",
                     wordcnt, cmd_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic [63:0] b;
        do_reset();
        b = 64'h0200abcd12345678;
        send_sync(0);
        send_word(64'h0100000400000009, 0);
        for (int i = 7; i >= 1; i--) step(1, b[i*8 +: 8], 0, 0);
        step(1, b[7:0], 1, 0);
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd !== b) begin
            n_err++;
            $display("FAIL simul_load valid=%b cmd=%h want 1 %h",
                     cmd_valid, cmd, b);
        end
        n_cmp++;
        if (overflow !== 1'b0 || wordcnt !== 16'd1) begin
            n_err++;
            $display("FAIL simul_flags ov=%b cnt=%0d want 0 1",
                     overflow, wordcnt);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_sync(1);
        step(1, 8'h01, 1, 0);
        step(1, 8'h00, 1, 0);
        step(1, 8'h00, 1, 0);
        repeat (TMO - 2) step(0, 8'h00, 1, 0);
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_early got %b want 0", timeout_err);
        end
        repeat (20 - (TMO - 2)) step(0, 8'h00, 1, 0);
        n_cmp++;
        if (timeout_err !== 1'b1 || aligned !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_flag to=%b al=%b want 1 1",
                     timeout_err, aligned);
        end
        send_word(64'h0100001500000000, 1);
        n_cmp++;
        if (cmd !== 64'h0100001500000000 || cmd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL tmo_word cmd=%h valid=%b want %h 1",
                     cmd, cmd_valid, 64'h0100001500000000);
        end
    endtask

    task automatic test_resync();
        do_reset();
        send_sync(1);
        step(1, 8'h11, 1, 0);
        step(1, 8'h22, 1, 0);
        step(1, 8'h33, 1, 0);
        step(1, 8'h44, 1, 0);
        send_sync(1);
        send_word(64'h03000042cafe0001, 1);
        n_cmp++;
        if (cmd !== 64'h03000042cafe0001 || cmd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL resync_word cmd=%h valid=%b want %h 1",
                     cmd, cmd_valid, 64'h03000042cafe0001);
        end
        step(0, 8'h00, 1, 0);
        n_cmp++;
        if (wordcnt !== m_cnt) begin
            n_err++;
            $display("FAIL resync_cnt got %0d want %0d", wordcnt, m_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_sync(0);
        send_word(64'h0500000600000007, 0);
        step(1, 8'h0a, 0, 0);
        step(1, 8'h0b, 0, 0);
        rstn = 0;
        #2;
        n_cmp++;
        if ({aligned, cmd_valid, overflow, timeout_err} !== 4'b0 ||
            cmd !== 64'h0 || wordcnt !== 16'h0) begin
            n_err++;
            $display("FAIL reset_mid al=%b v=%b cmd=%h cnt=%0d want all 0",
                     aligned, cmd_valid, cmd, wordcnt);
        end
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1;
        step(1, 8'h00, 1, 0);
        n_cmp++;
        if (aligned !== 1'b0) begin
            n_err++;
            $display("FAIL reset_lost_align got %b want 0", aligned);
        end
    endtask

    task automatic test_random();
        bit v;
        bit rdy;
        bit c;
        logic [7:0] d;
        do_reset();
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 39) == 0 || n == 0) begin
                for (int i = 0; i < NSYNC; i++)
                    step(1, 8'hff, $urandom_range(0, 9) < 7, 0);
                step(1, 8'h00, $urandom_range(0, 9) < 7, 0);
            end else if ($urandom_range(0, 49) == 0) begin
                repeat (TMO + 4) step(0, 8'h00, 1, 0);
            end
            v = $urandom_range(0, 3) != 0;
            rdy = $urandom_range(0, 9) < 6;
            c = $urandom_range(0, 15) == 0;
            d = ($urandom_range(0, 7) == 0) ? 8'hff : 8'($urandom);
            step(v, d, rdy, c);
            n_cmp++;
            if ({cmd_valid, cmd, aligned, overflow, timeout_err, wordcnt} !==
                {m_full, m_cmd, m_al, m_ov, m_to, m_cnt}) begin
                n_err++;
                $display("FAIL rand[%0d] v=%b cmd=%h al=%b ov=%b to=%b cnt=%0d want %b %h %b %b %b %0d",
                         n, cmd_valid, cmd, aligned, overflow, timeout_err,
                         wordcnt, m_full, m_cmd, m_al, m_ov, m_to, m_cnt);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sync_cmds();
        test_no_sync();
        test_backpressure();
        test_simultaneous();
        test_timeout();
        test_resync();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
